bsg_xor_accum: RTL and testbench

Parametrised, handshaked XOR engine that generalises the elementwise XOR cell to a streaming datapath. Each accepted beat computes `a_i ^ b_i`. Beats are then either emitted one-for-one (pass mode) or folded into a running XOR over a packet of up to `els_p` beats (fold mode). Typical uses are parity/checksum generation and scrambler-key mixing between two valid/ready channels.

---
 rtl/bsg_xor_pkg.sv | 19 +
 rtl/bsg_xor.sv | 12 +
 rtl/bsg_xor_accum.sv | 105 ++++++++++
 tb/tb_bsg_xor_accum.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/bsg_xor_pkg.sv
// Shared types and sizing helper for the streaming XOR accumulator.
package bsg_xor_pkg;

  typedef enum logic {
    e_xor_pass = 1'b0,
    e_xor_fold = 1'b1
  } bsg_xor_mode_e;

  typedef enum logic {
    e_idle = 1'b0,
    e_fold = 1'b1
  } bsg_xor_state_e;

  // Bits needed to hold a beat count of 0..els.
  function automatic int cnt_width(input int els);
    return $clog2(els + 1);
  endfunction

endpackage

// File: rtl/bsg_xor.sv
// Elementwise XOR cell.
module bsg_xor #(
  parameter int width_p = 16
) (
  input  logic [width_p-1:0] a_i,
  input  logic [width_p-1:0] b_i,
  output logic [width_p-1:0] o
);

  assign o = a_i ^ b_i;

endmodule

// File: rtl/bsg_xor_accum.sv
// Handshaked XOR engine: per-beat a^b, emitted one-for-one (pass) or
// folded across a packet of up to els_p beats (fold).
module bsg_xor_accum
  import bsg_xor_pkg::*;
#(
  parameter int width_p = 16,
  parameter int els_p   = 16,
  localparam int cnt_w_lp = cnt_width(els_p)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                v_i,
  output logic                ready_o,
  input  logic [width_p-1:0]  a_i,
  input  logic [width_p-1:0]  b_i,
  input  logic                last_i,
  input  logic                mode_i,
  output logic                v_o,
  output logic [width_p-1:0]  data_o,
  output logic [cnt_w_lp-1:0] count_o,
  input  logic                yumi_i
);

  bsg_xor_state_e        state_r, state_n;
  bsg_xor_mode_e         mode_r, mode_n;
  logic [width_p-1:0]    acc_r, acc_n;
  logic [cnt_w_lp-1:0]   cnt_r, cnt_n;
  logic                  v_r, v_n;
  logic [width_p-1:0]    data_r, data_n;
  logic [cnt_w_lp-1:0]   count_r, count_n;

  logic [width_p-1:0]    beat_x;
  logic [cnt_w_lp-1:0]   cnt_inc;
  logic                  accept, terminal;

  bsg_xor #(.width_p(width_p)) front (
    .a_i (a_i),
    .b_i (b_i),
    .o   (beat_x)
  );

  // Gating every beat on a free output slot keeps results strictly ordered.
  assign ready_o = ~v_r | yumi_i;
  assign accept  = v_i & ready_o;
  assign cnt_inc = cnt_r + cnt_w_lp'(1);

  always_comb begin
    terminal = 1'b0;
    if (state_r == e_idle)
      terminal = (mode_i == e_xor_pass) | last_i | (els_p == 1);
    else
      terminal = (mode_r == e_xor_pass) | last_i | (cnt_inc == cnt_w_lp'(els_p));
  end

  always_comb begin
    state_n = state_r;
    mode_n  = mode_r;
    acc_n   = acc_r;
    cnt_n   = cnt_r;
    data_n  = data_r;
    count_n = count_r;
    v_n     = v_r & ~yumi_i;
    if (accept) begin
      if (state_r == e_idle)
        mode_n = bsg_xor_mode_e'(mode_i);
      if (terminal) begin
        v_n     = 1'b1;
        data_n  = acc_r ^ beat_x;
        count_n = cnt_inc;
        acc_n   = '0;
        cnt_n   = '0;
        state_n = e_idle;
      end else begin
        acc_n   = acc_r ^ beat_x;
        cnt_n   = cnt_inc;
        state_n = e_fold;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= e_idle;
      mode_r  <= e_xor_pass;
      acc_r   <= '0;
      cnt_r   <= '0;
      v_r     <= 1'b0;
      data_r  <= '0;
      count_r <= '0;
    end else begin
      state_r <= state_n;
      mode_r  <= mode_n;
      acc_r   <= acc_n;
      cnt_r   <= cnt_n;
      v_r     <= v_n;
      data_r  <= data_n;
      count_r <= count_n;
    end
  end

  assign v_o     = v_r;
  assign data_o  = data_r;
  assign count_o = count_r;

endmodule

// File: tb/tb_bsg_xor_accum.sv
// Directed bench for bsg_xor_accum with els_p = 4 and hand-computed results.
module tb_bsg_xor_accum;

  localparam int W   = 16;
  localparam int ELS = 4;
  localparam int CW  = $clog2(ELS + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          v_i, ready, last_i, mode_i, v_o, yumi;
  logic [W-1:0]  a, b, data;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bsg_xor_accum #(.width_p(W), .els_p(ELS)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .v_i       (v_i),
    .ready_o   (ready),
    .a_i       (a),
    .b_i       (b),
    .last_i    (last_i),
    .mode_i    (mode_i),
    .v_o       (v_o),
    .data_o    (data),
    .count_o   (count),
    .yumi_i    (yumi)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One beat presented for exactly one edge; caller guarantees ready.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                      input logic tlast, input logic tmode);
    v_i = 1'b1; a = ta; b = tb; last_i = tlast; mode_i = tmode;
    @(posedge clk); #1;
    v_i = 1'b0;
  endtask

  task automatic drain;
    yumi = 1'b1;
    @(posedge clk); #1;
    yumi = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; v_i = 1'b0; a = '0; b = '0; last_i = 1'b0; mode_i = 1'b0; yumi = 1'b0;
    #1;
    chk("rst_v", v_o, 0);
    chk("rst_data", data, 0);
    chk("rst_count", count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rst_ready", ready, 1);

    // pass beat with consumer always taking
    yumi = 1'b1;
    send(16'h00FF, 16'h0F0F, 1'b0, 1'b0);
    chk("pass_v", v_o, 1);
    chk("pass_data", data, 16'h0FF0);
    chk("pass_count", count, 1);
    @(posedge clk); #1;
    chk("pass_clr", v_o, 0);
    yumi = 1'b0;

    // fold of 3 with last on beat 3
    send(16'h0001, 16'h0000, 1'b0, 1'b1);
    chk("f3_b1", v_o, 0);
    send(16'h0002, 16'h0000, 1'b0, 1'b1);
    chk("f3_b2", v_o, 0);
    send(16'h0004, 16'h0008, 1'b1, 1'b1);
    chk("f3_v", v_o, 1);
    chk("f3_data", data, 16'h000F);
    chk("f3_count", count, 3);
    drain();
    chk("f3_pulse", v_o, 0);

    // forced close at els_p=4, then two pending beats closed by a third
    for (int i = 0; i < 4; i++) begin
      send(16'h1111, 16'h0000, 1'b0, 1'b1);
      if (i < 3) chk("fc_pend", v_o, 0);
    end
    chk("fc_v", v_o, 1);
    chk("fc_data", data, 16'h0000);
    chk("fc_count", count, 4);
    yumi = 1'b1;
    send(16'h1111, 16'h0000, 1'b0, 1'b1);
    yumi = 1'b0;
    chk("fc_b5", v_o, 0);
    send(16'h1111, 16'h0000, 1'b0, 1'b0);
    chk("fc_b6", v_o, 0);
    send(16'h1111, 16'h0000, 1'b1, 1'b0);
    chk("fc_tail_v", v_o, 1);
    chk("fc_tail_data", data, 16'h1111);
    chk("fc_tail_count", count, 3);

    // backpressure: result held, pending pass beat waits, then swaps in
    v_i = 1'b1; a = 16'hAAAA; b = 16'h5555; last_i = 1'b0; mode_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_ready", ready, 0);
      chk("bp_hold", data, 16'h1111);
      chk("bp_count", count, 3);
    end
    yumi = 1'b1;
    @(posedge clk); #1;
    v_i = 1'b0;
    chk("bp_v", v_o, 1);
    chk("bp_data", data, 16'hFFFF);
    chk("bp_cnt", count, 1);
    @(posedge clk); #1;
    yumi = 1'b0;
    chk("bp_clr", v_o, 0);

    // mode is latched on the first beat only
    send(16'h0100, 16'h0000, 1'b0, 1'b1);
    send(16'h0020, 16'h0000, 1'b0, 1'b0);
    chk("ml_b2", v_o, 0);
    send(16'h0003, 16'h0000, 1'b1, 1'b0);
    chk("ml_v", v_o, 1);
    chk("ml_data", data, 16'h0123);
    chk("ml_count", count, 3);
    drain();

    // reset mid-packet discards the partial fold
    send(16'h00F0, 16'h0000, 1'b0, 1'b1);
    send(16'h00F0, 16'h0F00, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mr_v", v_o, 0);
    chk("mr_data", data, 0);
    chk("mr_count", count, 0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(16'h1234, 16'h4321, 1'b0, 1'b0);
    chk("mr_pass_v", v_o, 1);
    chk("mr_pass_data", data, 16'h5115);
    chk("mr_pass_count", count, 1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
